mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_fmt.sv | 71 +++++++
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   XLEN_DEF    : default data/address width
//   SZ_B/H/W    : d_size encodings (2'b11 is illegal and treated as misaligned)
//   state_e     : arbiter FSM state encoding
package mem_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned BE_W     = 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for data accesses (purely combinational).
//   addr_lo_i    : byte offset of the access within the word
//   size_i       : access size (SZ_B / SZ_H / SZ_W)
//   unsigned_i   : zero-extend loads instead of sign-extending
//   wdata_i      : store data from the requester (right-aligned)
//   rdata_i      : raw word returned by memory
//   be_o         : byte enables for the memory port
//   wdata_o      : store data replicated across lanes
//   rdata_o      : extracted and extended load data
//   misaligned_o : access cannot be issued as a single word access
// Lanes assume XLEN >= 32 with the four byte lanes at the bottom of the word.
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection for loads
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Enables, replication, extension and alignment check per size
    always_comb begin
        be_o         = '0;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b1;
        case (size_i)
            SZ_B: begin
                be_o         = 4'b0001 << addr_lo_i;
                wdata_o      = {(XLEN/8){wdata_i[7:0]}};
                rdata_o      = {{(XLEN-8){byte_v[7] & ~unsigned_i}}, byte_v};
                misaligned_o = 1'b0;
            end
            SZ_H: begin
                be_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {(XLEN/16){wdata_i[15:0]}};
                rdata_o      = {{(XLEN-16){half_v[15] & ~unsigned_i}}, half_v};
                misaligned_o = addr_lo_i[0];
            end
            SZ_W: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data
// accesses, one transaction outstanding at a time.
//   clk, rst            : clock, asynchronous active-low reset
//   if_req/if_addr      : fetch request (always a full word)
//   if_gnt              : fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata  : fetch completion, one cycle
//   d_req/d_we/d_addr/d_wdata/d_size/d_unsigned : data request
//   d_gnt               : data accepted (combinational, IDLE only)
//   d_rvalid/d_rdata/d_err : data completion, d_err flags misalignment
//   m_req/m_we/m_addr/m_be/m_wdata : registered memory request
//   m_ack/m_rdata       : one-cycle memory completion with read data
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [1:0]      d_size,
    input  logic            d_unsigned,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [BE_W-1:0] m_be,
    output logic [XLEN-1:0] m_wdata,
    input  logic            m_ack,
    input  logic [XLEN-1:0] m_rdata
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_e          state_q, state_d;
    logic            last_d_q, last_d_d;     // data was granted most recently
    logic            own_d_q, own_d_d;       // current transaction belongs to data
    logic [1:0]      alo_q, alo_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [XLEN-1:0] m_addr_q, m_addr_d;
    logic [BE_W-1:0] m_be_q, m_be_d;
    logic [XLEN-1:0] m_wdata_q, m_wdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            d_err_q, d_err_d;

    logic [1:0]      fmt_alo;
    logic [1:0]      fmt_size;
    logic            fmt_uns;
    logic [BE_W-1:0] fmt_be;
    logic [XLEN-1:0] fmt_wdata;
    logic [XLEN-1:0] fmt_rdata;
    logic            fmt_mis;

    // Formatter sees the live request while granting, the latched one afterwards
    assign fmt_alo  = (state_q == IDLE) ? d_addr[1:0] : alo_q;
    assign fmt_size = (state_q == IDLE) ? d_size      : size_q;
    assign fmt_uns  = (state_q == IDLE) ? d_unsigned  : uns_q;

    mem_lane_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .addr_lo_i    (fmt_alo),
        .size_i       (fmt_size),
        .unsigned_i   (fmt_uns),
        .wdata_i      (d_wdata),
        .rdata_i      (m_rdata),
        .be_o         (fmt_be),
        .wdata_o      (fmt_wdata),
        .rdata_o      (fmt_rdata),
        .misaligned_o (fmt_mis)
    );

    // Next-state, grants and register updates
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        own_d_d     = own_d_q;
        alo_d       = alo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_be_d      = m_be_q;
        m_wdata_d   = m_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, the requester not granted last wins
                if (d_req && (!if_req || !last_d_q)) begin
                    d_gnt = 1'b1;
                end else if (if_req) begin
                    if_gnt = 1'b1;
                end

                if (d_gnt) begin
                    last_d_d = 1'b1;
                    own_d_d  = 1'b1;
                    alo_d    = d_addr[1:0];
                    size_d   = d_size;
                    uns_d    = d_unsigned;
                    if (fmt_mis) begin
                        // Never reaches memory; complete with an error next cycle
                        state_d    = RESP;
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b1;
                        d_rdata_d  = '0;
                    end else begin
                        state_d   = WAIT;
                        m_req_d   = 1'b1;
                        m_we_d    = d_we;
                        m_addr_d  = d_addr & ALIGN_MASK;
                        m_be_d    = fmt_be;
                        m_wdata_d = d_we ? fmt_wdata : '0;
                    end
                end else if (if_gnt) begin
                    last_d_d  = 1'b0;
                    own_d_d   = 1'b0;
                    state_d   = WAIT;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr & ALIGN_MASK;
                    m_be_d    = 4'b1111;
                    m_wdata_d = '0;
                end
            end

            WAIT: begin
                if (m_ack) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    if (own_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = m_we_q ? '0 : fmt_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = m_rdata;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            own_d_q     <= 1'b0;
            alo_q       <= 2'b00;
            size_q      <= SZ_W;
            uns_q       <= 1'b0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_be_q      <= '0;
            m_wdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            own_d_q     <= own_d_d;
            alo_q       <= alo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_be_q      <= m_be_d;
            m_wdata_q   <= m_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_be      = m_be_q;
    assign m_wdata   = m_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed requests push expected memory
// commands and expected responses into queues; a memory responder and a
// response monitor pop and compare independently of the stimulus.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [XLEN-1:0] d_addr = '0;
    logic [XLEN-1:0] d_wdata = '0;
    logic [1:0]      d_size = 2'b10;
    logic            d_unsigned = 1'b0;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            d_err;
    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [3:0]      m_be;
    logic [XLEN-1:0] m_wdata;
    logic            m_ack = 1'b0;
    logic [XLEN-1:0] m_rdata = '0;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_be       (m_be),
        .m_wdata    (m_wdata),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } mem_t;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    mem_t mem_q[$];
    rsp_t rsp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_gnt = 0;
    int   last_rv = 0;
    bit   mem_en = 1'b1;
    bit   busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        mem_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata; e.delay = delay;
        mem_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic is_d, input logic err, input logic [31:0] rdata);
        rsp_t e;
        e.is_d = is_d; e.err = err; e.rdata = rdata;
        rsp_q.push_back(e);
    endtask

    // Memory responder: checks each new command, then acks after its delay
    initial begin
        mem_t cur;
        int   cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (m_ack) begin
                    m_ack = 1'b0;
                    busy  = 1'b0;
                end else if (m_req) begin
                    if (!busy) begin
                        if (mem_q.size() == 0) begin
                            fail_evt("unexpected m_req");
                        end else begin
                            cur  = mem_q.pop_front();
                            busy = 1'b1;
                            cnt  = 0;
                            chk("m_addr", m_addr, cur.addr);
                            chk("m_we", 32'(m_we), 32'(cur.we));
                            if (cur.we) begin
                                chk("m_be", 32'(m_be), 32'(cur.be));
                                chk("m_wdata", m_wdata, cur.wdata);
                            end
                        end
                    end else begin
                        chk("m_addr stable", m_addr, cur.addr);
                    end
                    if (busy) begin
                        if (cnt == cur.delay) begin
                            m_ack   = 1'b1;
                            m_rdata = cur.rdata;
                        end else begin
                            cnt++;
                        end
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (if_gnt && d_gnt) fail_evt("both grants high");
            if (d_err && !d_rvalid) fail_evt("d_err without d_rvalid");
            if (if_rvalid || d_rvalid) begin
                last_rv = cyc;
                if (if_rvalid && d_rvalid) begin
                    fail_evt("both rvalid high");
                end else if (rsp_q.size() == 0) begin
                    fail_evt("unexpected rvalid");
                end else begin
                    e = rsp_q.pop_front();
                    chk("rvalid owner is data", 32'(d_rvalid), 32'(e.is_d));
                    chk("rdata", d_rvalid ? d_rdata : if_rdata, e.rdata);
                    chk("d_err", 32'(d_err), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_gnt(input logic is_d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt : if_gnt) begin
                got      = 1'b1;
                last_gnt = cyc;
            end
        end
        if (!got) fail_evt("grant timeout");
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && mem_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) fail_evt("completion timeout");
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        wait_gnt(1'b0);
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_done();
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_unsigned = uns;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_done();
    endtask

    task automatic ld(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] mdata, input logic [31:0] exp);
        exp_mem(1'b0, addr & 32'hFFFF_FFFC, 4'h0, 32'h0, mdata, 0);
        exp_rsp(1'b1, 1'b0, exp);
        do_data(1'b0, addr, 32'h0, size, uns);
    endtask

    task automatic st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] mwdata);
        exp_mem(1'b1, addr & 32'hFFFF_FFFC, be, mwdata, 32'h5A5A_5A5A, 0);
        exp_rsp(1'b1, 1'b0, 32'h0);
        do_data(1'b1, addr, wdata, size, 1'b0);
    endtask

    task automatic mis(input logic we, input logic [31:0] addr, input logic [1:0] size);
        exp_rsp(1'b1, 1'b1, 32'h0);
        do_data(we, addr, 32'hFFFF_FFFF, size, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  gc[4];
        bit  gd[4];
        int  g;
        bit  got;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset m_req", 32'(m_req), 32'h0);
        chk("reset m_we", 32'(m_we), 32'h0);
        chk("reset m_be", 32'(m_be), 32'h0);
        chk("reset m_addr", m_addr, 32'h0);
        chk("reset m_wdata", m_wdata, 32'h0);
        chk("reset if_rvalid", 32'(if_rvalid), 32'h0);
        chk("reset d_rvalid", 32'(d_rvalid), 32'h0);
        chk("reset d_err", 32'(d_err), 32'h0);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Both requesters held: data wins the first tie, then strict alternation
        exp_mem(1'b0, 32'h500, 4'h0, 32'h0, 32'h1111_1111, 0);
        exp_mem(1'b0, 32'h600, 4'h0, 32'h0, 32'h2222_2222, 0);
        exp_mem(1'b0, 32'h500, 4'h0, 32'h0, 32'h3333_3333, 0);
        exp_mem(1'b0, 32'h600, 4'h0, 32'h0, 32'h4444_4444, 0);
        exp_rsp(1'b1, 1'b0, 32'h1111_1111);
        exp_rsp(1'b0, 1'b0, 32'h2222_2222);
        exp_rsp(1'b1, 1'b0, 32'h3333_3333);
        exp_rsp(1'b0, 1'b0, 32'h4444_4444);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_size = SZ_W; d_unsigned = 1'b0;
        if_req = 1'b1; if_addr = 32'h600;
        g = 0;
        for (int i = 0; i < 60 && g < 4; i++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                gc[g] = cyc;
                gd[g] = d_gnt;
                g++;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
        chk("tie grant count", 32'(g), 32'd4);
        if (g == 4) begin
            chk("tie grant0 data", 32'(gd[0]), 32'h1);
            chk("tie grant1 data", 32'(gd[1]), 32'h0);
            chk("tie grant2 data", 32'(gd[2]), 32'h1);
            chk("tie grant3 data", 32'(gd[3]), 32'h0);
            for (int i = 1; i < 4; i++) chk("grant period", 32'(gc[i] - gc[i-1]), 32'd3);
        end
        wait_done();
        if (g == 4) chk("gnt to rvalid latency", 32'(last_rv - gc[3]), 32'd2);

        // Fetch with a slow memory; low address bits ignored on fetch
        exp_mem(1'b0, 32'h104, 4'h0, 32'h0, 32'hDEAD_BEEF, 3);
        exp_rsp(1'b0, 1'b0, 32'hDEAD_BEEF);
        do_fetch(32'h104);
        chk("slow fetch latency", 32'(last_rv - last_gnt), 32'd5);
        exp_mem(1'b0, 32'h104, 4'h0, 32'h0, 32'h0102_0304, 0);
        exp_rsp(1'b0, 1'b0, 32'h0102_0304);
        do_fetch(32'h107);

        // Loads: lane extraction and extension
        ld(32'h203, SZ_B, 1'b1, 32'h80FF_1234, 32'h0000_0080);
        chk("load latency", 32'(last_rv - last_gnt), 32'd2);
        ld(32'h203, SZ_B, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80);
        ld(32'h202, SZ_H, 1'b1, 32'h80FF_1234, 32'h0000_80FF);
        ld(32'h202, SZ_H, 1'b0, 32'h80FF_1234, 32'hFFFF_80FF);
        ld(32'h200, SZ_H, 1'b0, 32'h80FF_1234, 32'h0000_1234);
        ld(32'h201, SZ_B, 1'b0, 32'h80FF_1234, 32'h0000_0012);
        ld(32'h204, SZ_W, 1'b0, 32'h80FF_1234, 32'h80FF_1234);

        // Stores: enables and lane replication, completion data is zero
        st(32'h301, SZ_B, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        st(32'h302, SZ_H, 32'h0000_CDEF, 4'b1100, 32'hCDEF_CDEF);
        st(32'h300, SZ_W, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        // Misaligned and illegal-size accesses never reach memory
        mis(1'b0, 32'h402, SZ_W);
        mis(1'b1, 32'h401, SZ_H);
        mis(1'b0, 32'h400, 2'b11);

        // Reset while a fetch is waiting on memory
        exp_mem(1'b0, 32'h800, 4'h0, 32'h0, 32'hBAD0_BAD0, 20);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h800;
        wait_gnt(1'b0);
        @(posedge clk); #1;
        if_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (m_req) got = 1'b1;
        end
        if (!got) fail_evt("m_req timeout before reset");
        #2;
        rst = 1'b0;
        #1;
        chk("async reset m_req", 32'(m_req), 32'h0);
        chk("async reset m_addr", m_addr, 32'h0);
        chk("async reset m_be", 32'(m_be), 32'h0);
        mem_en = 1'b0;
        busy = 1'b0;
        mem_q.delete();
        rsp_q.delete();
        m_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        m_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale ack if_rvalid", 32'(if_rvalid), 32'h0);
            chk("stale ack m_req", 32'(m_req), 32'h0);
        end
        mem_en = 1'b1;

        // Normal service after the abandoned transaction
        ld(32'h700, SZ_W, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
